// File: rtl/inc_seq_pkg.sv
// Shared types and constants for the increment sequencer.
package inc_seq_pkg;

  localparam int SEQ_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } seq_state_e;

endpackage

// File: rtl/inc_seq_shadow.sv
// Shadow model of the downstream counter. It tracks the value the counter
// should hold and raises a sticky flag the first time the two disagree.
module inc_seq_shadow
  import inc_seq_pkg::*;
#(
  parameter int W = SEQ_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cnt_rst,
  input  logic [W-1:0] ui,
  input  logic         en,
  input  logic [W-1:0] cnt_out,
  output logic         mismatch
);

  logic [W-1:0] r_shadow;
  logic         r_shadow_valid;

  // Follow the counter's own update rules on the same edges it uses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow       <= '0;
      r_shadow_valid <= 1'b0;
    end else if (cnt_rst) begin
      r_shadow       <= ui;
      r_shadow_valid <= 1'b1;
    end else if (en) begin
      r_shadow       <= r_shadow + W'(1);
    end
  end

  // Divergence is latched and only cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mismatch <= 1'b0;
    end else if (r_shadow_valid && (cnt_out != r_shadow)) begin
      mismatch <= 1'b1;
    end
  end

endmodule

// File: rtl/inc_sequencer.sv
// Command sequencer for the 4-bit counter: turns load / increment-burst
// commands into counter rst/ui load cycles and en pulses.
// Optional shadow checking is enabled with INC_SEQUENCER_SHADOW_CHECK_EN.
module inc_sequencer
  import inc_seq_pkg::*;
#(
  parameter int W = SEQ_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic         cmd_load,
  input  logic [W-1:0] cmd_data,
  input  logic         hold,
  output logic         cnt_rst,
  output logic [W-1:0] ui,
  output logic         en,
  output logic         busy,
  output logic         done,
  input  logic [W-1:0] cnt_out,
  output logic         mismatch
);

  seq_state_e   r_state;
  logic [W-1:0] r_remaining;

  assign cmd_ready = (r_state == IDLE);
  assign busy      = (r_state != IDLE);

  // Command FSM with registered counter-control outputs. The first enable
  // pulse of a burst is launched from the accept edge so it appears in the
  // cycle right after acceptance; later pulses are gated by hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_remaining <= '0;
      ui          <= '0;
      cnt_rst     <= 1'b0;
      en          <= 1'b0;
      done        <= 1'b0;
    end else begin
      cnt_rst <= 1'b0;
      done    <= 1'b0;
      unique case (r_state)
        IDLE: begin
          en <= 1'b0;
          if (cmd_valid) begin
            if (cmd_load) begin
              ui      <= cmd_data;
              cnt_rst <= 1'b1;
              r_state <= LOAD;
            end else if (cmd_data == '0) begin
              done    <= 1'b1;
              r_state <= DONE;
            end else begin
              en          <= 1'b1;
              r_remaining <= cmd_data;
              r_state     <= RUN;
            end
          end
        end
        LOAD: begin
          done    <= 1'b1;
          r_state <= DONE;
        end
        RUN: begin
          if (en) begin
            if (r_remaining == W'(1)) begin
              en          <= 1'b0;
              done        <= 1'b1;
              r_remaining <= '0;
              r_state     <= DONE;
            end else begin
              r_remaining <= r_remaining - W'(1);
              en          <= !hold;
            end
          end else begin
            en <= !hold;
          end
        end
        DONE: begin
          en      <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef INC_SEQUENCER_SHADOW_CHECK_EN
  inc_seq_shadow #(.W(W)) u_shadow (
    .clk      (clk),
    .rst_n    (rst_n),
    .cnt_rst  (cnt_rst),
    .ui       (ui),
    .en       (en),
    .cnt_out  (cnt_out),
    .mismatch (mismatch)
  );
`else
  logic w_unused_cnt_out;
  assign w_unused_cnt_out = ^cnt_out;
  assign mismatch         = 1'b0;
`endif

endmodule

// File: tb/tb_inc_sequencer.sv
// Scoreboard bench for inc_sequencer with a behavioural counter attached.
module tb_inc_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_load = 1'b0;
  logic [3:0] cmd_data = '0;
  logic       hold = 1'b0;
  logic       cnt_rst;
  logic [3:0] ui;
  logic       en;
  logic       busy;
  logic       done;
  logic [3:0] cnt_out;
  logic       mismatch;

  logic [3:0] ctr = '0;
  logic [3:0] inj = '0;
  int         cyc = 0;
  int         n_checks = 0;
  int         n_err = 0;
  bit         exp_mis = 1'b0;

  typedef struct {
    int         pulses;
    int         rsts;
    logic [3:0] cnt;
    logic [3:0] uiv;
    int         lat;
  } item_t;

  item_t      q[$];
  logic [3:0] exp_cnt = '0;
  logic [3:0] exp_ui = '0;

  inc_sequencer #(.W(4)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_load(cmd_load), .cmd_data(cmd_data), .hold(hold), .cnt_rst(cnt_rst),
    .ui(ui), .en(en), .busy(busy), .done(done), .cnt_out(cnt_out),
    .mismatch(mismatch)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // External counter: rst loads ui, en increments.
  always @(posedge clk) begin
    if (cnt_rst) ctr <= ui;
    else if (en) ctr <= ctr + 4'd1;
  end
  assign cnt_out = ctr ^ inj;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: a load sets counter to data, a burst adds data modulo 16.
  function automatic void expect_cmd(input bit ld, input logic [3:0] d, input bit timed);
    item_t it;
    if (ld) begin
      exp_cnt = d;
      exp_ui  = d;
    end else begin
      exp_cnt = exp_cnt + d;
    end
    it.pulses = ld ? 0 : int'(d);
    it.rsts   = ld ? 1 : 0;
    it.cnt    = exp_cnt;
    it.uiv    = exp_ui;
    it.lat    = !timed ? -1 : (ld ? 2 : int'(d) + 1);
    q.push_back(it);
  endfunction

  // Monitor: observes accept, counts pulses, checks each completion.
  int  m_pulses = 0, m_rsts = 0, m_acc = 0;
  bit  m_chk_ready = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      m_pulses    = 0;
      m_rsts      = 0;
      m_chk_ready = 1'b0;
    end else begin
      if (m_chk_ready) begin
        check("ready_after_done", {31'd0, cmd_ready}, 32'd1);
        m_chk_ready = 1'b0;
      end
      if (cmd_valid && cmd_ready) begin
        m_acc    = cyc;
        m_pulses = 0;
        m_rsts   = 0;
      end
      if (en) m_pulses++;
      if (cnt_rst) begin
        m_rsts++;
        check("ui_during_load", {28'd0, ui}, {28'd0, exp_ui});
      end
      if (done) begin
        if (q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          item_t it;
          it = q.pop_front();
          check("en_pulses", m_pulses, it.pulses);
          check("cnt_rst_cycles", m_rsts, it.rsts);
          check("counter_value", {28'd0, cnt_out}, {28'd0, it.cnt});
          check("ui_value", {28'd0, ui}, {28'd0, it.uiv});
          check("mismatch", {31'd0, mismatch}, {31'd0, exp_mis});
          if (it.lat >= 0) check("done_latency", cyc - m_acc, it.lat);
        end
        m_chk_ready = 1'b1;
      end
    end
  end

  task automatic wait_ready();
    bit ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (cmd_ready) begin ok = 1'b1; break; end
    end
    if (!ok) check("ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
  endtask

  task automatic issue(input bit ld, input logic [3:0] d, input bit timed);
    expect_cmd(ld, d, timed);
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_load = ld; cmd_data = d;
    wait_ready();
  endtask

  task automatic wait_idle(input bit rnd_hold);
    bit ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      hold = rnd_hold ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
      if (!busy) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    hold = 1'b0;
    if (!ok) check("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic send(input bit ld, input logic [3:0] d, input bit rnd_hold);
    issue(ld, d, !rnd_hold);
    #1 cmd_valid = 1'b0;
    wait_idle(rnd_hold);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cnt_rst"}, {31'd0, cnt_rst}, 32'd0);
    check({tag, "_en"}, {31'd0, en}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_ui"}, {28'd0, ui}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_mismatch"}, {31'd0, mismatch}, 32'd0);
    check({tag, "_ready"}, {31'd0, cmd_ready}, 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] pat;
    logic [3:0] pre;
    int         seen;

    repeat (3) @(posedge clk);
    #1 check_reset_outputs("reset");
    rst_n = 1'b1;

    // Directed cases from the plan.
    send(1'b1, 4'h3, 1'b0);
    send(1'b0, 4'd5, 1'b0);
    send(1'b1, 4'hE, 1'b0);
    send(1'b0, 4'd3, 1'b0);
    send(1'b0, 4'd0, 1'b0);
    send(1'b0, 4'hF, 1'b0);

    // Burst of 4 with hold raised so the enable train reads 1,0,0,1,1,1.
    issue(1'b0, 4'd4, 1'b0);
    pat = '0;
    for (int i = 0; i < 6; i++) begin
      #1;
      cmd_valid = 1'b0;
      hold = (i < 2);
      @(negedge clk);
      pat = {pat[4:0], en};
      @(posedge clk);
    end
    #1 hold = 1'b0;
    check("hold_pattern", {26'd0, pat}, 32'b100111);
    wait_idle(1'b0);

    // Second command held valid while the first is still running.
    issue(1'b0, 4'd5, 1'b1);
    #1 cmd_load = 1'b1; cmd_data = 4'h9;
    expect_cmd(1'b1, 4'h9, 1'b1);
    wait_ready();
    #1 cmd_valid = 1'b0;
    wait_idle(1'b0);

    // Abort a burst of 6 after two pulses.
    pre = exp_cnt;
    issue(1'b0, 4'd6, 1'b0);
    #1 cmd_valid = 1'b0;
    seen = 0;
    for (int k = 0; k < 20 && seen < 2; k++) begin
      @(negedge clk);
      if (en) seen++;
    end
    check("pulses_before_abort", seen, 2);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1 check_reset_outputs("abort");
    q.delete();
    exp_cnt = pre + 4'd2;
    exp_ui  = 4'h0;
    exp_mis = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("abort_no_done", {31'd0, done}, 32'd0);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("post_abort_done", {31'd0, done}, 32'd0);
    check("post_abort_busy", {31'd0, busy}, 32'd0);

    // Randomized commands.
    for (int n = 0; n < 30; n++) begin
      send(($urandom_range(0, 2) == 0), 4'($urandom), 1'($urandom_range(0, 1)));
    end

`ifdef INC_SEQUENCER_SHADOW_CHECK_EN
    send(1'b1, 4'h5, 1'b0);
    @(posedge clk); #1 inj = 4'h2;
    @(posedge clk); #1 inj = 4'h0; exp_mis = 1'b1;
    @(negedge clk);
    check("mismatch_set", {31'd0, mismatch}, 32'd1);
    send(1'b0, 4'd2, 1'b0);
    check("mismatch_sticky", {31'd0, mismatch}, 32'd1);
    @(posedge clk); #2 rst_n = 1'b0;
    #1 check("mismatch_cleared", {31'd0, mismatch}, 32'd0);
    exp_mis = 1'b0;
    exp_ui  = 4'h0;
    @(posedge clk); #1 rst_n = 1'b1;
`endif

    repeat (3) @(posedge clk);
    check("queue_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
